// File: rtl/vending_change_dispenser.sv
// rtl/vending_change_dispenser.sv - greedy 50/10/5 change dispenser with coin inventory and hopper handshake
// Optional ack watchdog: define CHANGE_TIMEOUT_EN.
module vending_change_dispenser #(
  parameter int AMT_W       = 7,
  parameter int INV_W       = 4,
  parameter int INIT_50     = 2,
  parameter int INIT_10     = 5,
  parameter int INIT_5      = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             restock,
  output logic             disp_valid,
  output logic [1:0]       disp_coin,
  input  logic             disp_ack,
  output logic             busy,
  output logic [AMT_W-1:0] remaining,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [INV_W-1:0] inv_50,
  output logic [INV_W-1:0] inv_10,
  output logic [INV_W-1:0] inv_5
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_FINISH   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_50   = 2'b11;

  localparam logic [AMT_W-1:0] VAL_50 = AMT_W'(50);
  localparam logic [AMT_W-1:0] VAL_10 = AMT_W'(10);
  localparam logic [AMT_W-1:0] VAL_5  = AMT_W'(5);

  localparam logic [INV_W-1:0] INV_INIT_50 = INV_W'(INIT_50);
  localparam logic [INV_W-1:0] INV_INIT_10 = INV_W'(INIT_10);
  localparam logic [INV_W-1:0] INV_INIT_5  = INV_W'(INIT_5);
  localparam logic [INV_W-1:0] INV_ONE     = INV_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AMT_W-1:0] r_remaining;
  logic [INV_W-1:0] r_inv_50;
  logic [INV_W-1:0] r_inv_10;
  logic [INV_W-1:0] r_inv_5;
  logic [1:0]       r_coin;
  logic             r_done;
  logic             r_short;
  logic [1:0]       w_sel_coin;
  logic [AMT_W-1:0] w_coin_val;
  logic             w_accept;
  logic             w_ack;
  logic             w_timeout;

  // Greedy choice: largest coin that fits the amount owed and is still in stock
  always_comb begin
    w_sel_coin = COIN_NONE;
    if (r_remaining >= VAL_50 && r_inv_50 != '0) begin
      w_sel_coin = COIN_50;
    end else if (r_remaining >= VAL_10 && r_inv_10 != '0) begin
      w_sel_coin = COIN_10;
    end else if (r_remaining >= VAL_5 && r_inv_5 != '0) begin
      w_sel_coin = COIN_5;
    end
  end

  // Value of the coin currently offered to the hopper
  always_comb begin
    w_coin_val = '0;
    case (r_coin)
      COIN_50: w_coin_val = VAL_50;
      COIN_10: w_coin_val = VAL_10;
      COIN_5:  w_coin_val = VAL_5;
      default: w_coin_val = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        w_state_nxt = (w_sel_coin == COIN_NONE) ? S_FINISH : S_DISPENSE;
      end
      S_DISPENSE: begin
        if (disp_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = S_SELECT;
        end else if (w_timeout) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Refund amount, inventories, latched coin and end-of-refund pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_inv_50    <= INV_INIT_50;
      r_inv_10    <= INV_INIT_10;
      r_inv_5     <= INV_INIT_5;
      r_coin      <= COIN_NONE;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
    end else begin
      r_done  <= (r_state == S_FINISH);
      r_short <= (r_state == S_FINISH) && (r_remaining != '0);
      // Restock is only honoured while idle; it lands on the same edge as an accept
      // so the following SELECT already sees the reloaded counts.
      if (r_state == S_IDLE && restock) begin
        r_inv_50 <= INV_INIT_50;
        r_inv_10 <= INV_INIT_10;
        r_inv_5  <= INV_INIT_5;
      end
      if (w_accept) begin
        r_remaining <= req_amount;
      end
      if (r_state == S_SELECT) begin
        r_coin <= w_sel_coin;
      end
      // A coin only counts once the hopper acknowledges it
      if (w_ack) begin
        r_remaining <= r_remaining - w_coin_val;
        case (r_coin)
          COIN_50: r_inv_50 <= r_inv_50 - INV_ONE;
          COIN_10: r_inv_10 <= r_inv_10 - INV_ONE;
          COIN_5:  r_inv_5  <= r_inv_5 - INV_ONE;
          default: r_inv_5  <= r_inv_5;
        endcase
      end
    end
  end

`ifdef CHANGE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_fault;

  assign w_timeout = (r_state == S_DISPENSE) && !disp_ack && (r_tmo_cnt == TMO_LAST);

  // Ack watchdog: counts consecutive unacknowledged DISPENSE cycles; fault is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_fault   <= 1'b0;
    end else begin
      if (r_state != S_DISPENSE || disp_ack) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
      if (w_timeout) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign fault = r_fault;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = |TIMEOUT_CYC;
  assign w_timeout    = 1'b0;
  assign fault        = 1'b0;
`endif

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign disp_valid = (r_state == S_DISPENSE);
  assign disp_coin  = (r_state == S_DISPENSE) ? r_coin : COIN_NONE;
  assign remaining  = r_remaining;
  assign done       = r_done;
  assign short      = r_short;
  assign inv_50     = r_inv_50;
  assign inv_10     = r_inv_10;
  assign inv_5      = r_inv_5;

endmodule

// File: doc/vending_change_dispenser.md
Name: vending_change_dispenser

Overview:
- Sequences the vending machine's change return once a purchase or cancel has fixed the refund amount.
- Pays the refund with a greedy 50/10/5 coin sequence and tracks a per-denomination coin inventory.
- Drives the coin hopper over a valid/ack handshake, one coin per transaction.
- Sits between the vending FSM (requester) and the hopper (dispense resource).

Parameters:
AMT_W, 7, width of refund amount and remaining counter
INV_W, 4, width of each inventory counter
INIT_50, 2, inventory of 50-coins after reset/restock
INIT_10, 5, inventory of 10-coins after reset/restock
INIT_5, 5, inventory of 5-coins after reset/restock
TIMEOUT_CYC, 16, ack watchdog limit (used only with CHANGE_TIMEOUT_EN)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  refund request
req_amount  in  AMT_W  refund value in currency units
req_ready  out  1  high in IDLE; request is accepted on req_valid && req_ready
restock  in  1  reload all inventories to INIT_*; honoured in IDLE only
disp_valid  out  1  coin dispense request to hopper
disp_coin  out  2  00 none, 01 = 5, 10 = 10, 11 = 50
disp_ack  in  1  hopper has released the coin
busy  out  1  state != IDLE
remaining  out  AMT_W  refund still owed
done  out  1  one-cycle pulse at end of refund
short  out  1  valid with done; refund not fully paid
fault  out  1  sticky watchdog fault (tied 0 without macro)
inv_50, inv_10, inv_5  out  INV_W each  current inventories

Behaviour:
- Reset (async, rst_n low):
  - state IDLE, remaining 0, inventories INIT_*.
  - disp_valid, disp_coin, done, short, fault, busy all 0; req_ready 1.
  - Reset mid-DISPENSE drops disp_valid immediately; the in-flight coin is not counted.
- Outputs are Moore-decoded from registered state/regs, except that done and short are registered pulses.
- FSM IDLE -> SELECT -> DISPENSE -> SELECT ... -> FINISH -> IDLE.
- IDLE:
  - On accept, remaining <= req_amount and next state is SELECT.
  - restock loads INIT_* at the same edge; with simultaneous restock and accept, the new inventory is used.
  - restock outside IDLE is ignored.
- SELECT (one cycle): first match wins:
  - remaining >= 50 and inv_50 > 0 -> coin 11
  - else remaining >= 10 and inv_10 > 0 -> coin 10
  - else remaining >= 5 and inv_5 > 0 -> coin 01
  - else -> FINISH
- DISPENSE:
  - disp_valid = 1; disp_coin is held stable until ack.
  - On disp_ack: remaining -= coin value, matching inventory decrements by 1, next state SELECT.
  - Minimum 2 cycles per coin.
- disp_ack while disp_valid = 0 is ignored.
- Inventories never underflow; a coin is only selected when its count > 0.
- FINISH (one cycle): next state IDLE.
  - done = 1 for one cycle in the cycle after FINISH; short = 1 in the same cycle when remaining != 0.
  - remaining holds until the next accept.
- Amounts not divisible by 5 leave an unpayable residue, reported via short.
- req_amount 0: done after SELECT/FINISH, no disp_valid, short 0.
- req_valid while busy is ignored and not queued.
- Latency: accept at edge N, disp_valid visible after edge N+1.

Optional Feature:
CHANGE_TIMEOUT_EN:
- Defined:
  - A counter runs while in DISPENSE.
  - If disp_ack is absent for TIMEOUT_CYC consecutive cycles: disp_valid drops, no inventory/remaining change, next state FINISH (done with short 1), fault set.
  - fault is sticky until reset.
- Undefined: DISPENSE waits indefinitely; fault constant 0; no counter logic.

Test Plan:
1. After reset, request 65, ack every DISPENSE cycle -> coins 11, 10, 01. Then done 1, short 0, remaining 0, inv 1/4/4.
2. Fresh reset, request 100 then request 60:
   - 100 -> 11, 11, inv_50 0.
   - 60 -> 10 ×5 then 01 ×2; done short 0; inv_10 0, inv_5 3.
3. Request 17 -> coins 10, 01; done with short 1, remaining 2.
4. Request 0 -> done within 3 cycles of accept, disp_valid never high, short 0.
5. Handshake stall and reset:
   - Hold disp_ack low 5 cycles in DISPENSE -> disp_valid/disp_coin stable.
   - req_valid and restock ignored during the stall.
   - Assert rst_n low mid-stall -> disp_valid 0 immediately, inventories INIT.
6. With CHANGE_TIMEOUT_EN, no ack for 16 cycles -> disp_valid drops, done + short, fault 1 until reset, inventory unchanged.
